// File: rtl/armleocpu_tlb.sv
`default_nettype none
// ============================================================================
// Module   : armleocpu_tlb
// Brief    : Fully-associative translation cache in front of armleocpu_ptw.
//            RESOLVE looks up a 20-bit VPN with one cycle of latency. WRITE
//            fills or updates an entry, and slots are replaced in FIFO order
//            through a round-robin pointer. INVALIDATE_ALL flushes the cache.
// Options  : ARMLEOCPU_TLB_STATS_EN adds the 32-bit hit and miss counters
//            stat_hits and stat_misses.
// Revision : 1.0 - initial release
// ============================================================================
module armleocpu_tlb #(
    parameter int ENTRIES   = 16,
    parameter int ENTRIES_W = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  command,
    input  logic [19:0] vaddr_input,
    input  logic [7:0]  accesstag_w,
    input  logic [21:0] phys_w,
    output logic        resolve_done,
    output logic        resolve_miss,
    output logic [7:0]  resolve_accesstag,
    output logic [21:0] resolve_phys
`ifdef ARMLEOCPU_TLB_STATS_EN
    ,
    output logic [31:0] stat_hits,
    output logic [31:0] stat_misses
`endif
);

    localparam logic [1:0] c_CMD_NONE       = 2'd0;
    localparam logic [1:0] c_CMD_RESOLVE    = 2'd1;
    localparam logic [1:0] c_CMD_WRITE      = 2'd2;
    localparam logic [1:0] c_CMD_INVALIDATE = 2'd3;

    // Entry storage. Only the valid bits are reset; tag and data are don't-care while invalid.
    logic [ENTRIES-1:0]   r_valid;
    logic [19:0]          r_tag    [ENTRIES];
    logic [7:0]           r_access [ENTRIES];
    logic [21:0]          r_phys   [ENTRIES];
    logic [ENTRIES_W-1:0] r_ptr;

    logic                 r_done;
    logic                 r_miss;
    logic [7:0]           r_res_access;
    logic [21:0]          r_res_phys;

    logic                 w_hit;
    logic [ENTRIES_W-1:0] w_hit_idx;
    logic [ENTRIES_W-1:0] w_wr_idx;

    // Associative match over all valid entries. The loop scans downward so the lowest index wins.
    always_comb begin
        w_hit     = 1'b0;
        w_hit_idx = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (r_valid[i] && (r_tag[i] == vaddr_input)) begin
                w_hit     = 1'b1;
                w_hit_idx = ENTRIES_W'(i);
            end
        end
    end

    // A WRITE to a page that is already cached updates it in place. Otherwise it takes the FIFO slot.
    assign w_wr_idx = w_hit ? w_hit_idx : r_ptr;

    // Valid bits and replacement pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            r_ptr   <= '0;
        end else begin
            case (command)
                c_CMD_WRITE: begin
                    if (!w_hit) begin
                        r_valid[r_ptr] <= 1'b1;
                        r_ptr          <= r_ptr + {{(ENTRIES_W-1){1'b0}}, 1'b1};
                    end
                end
                c_CMD_INVALIDATE: begin
                    r_valid <= '0;
                    r_ptr   <= '0;
                end
                default: begin
                end
            endcase
        end
    end

    // Tag and data arrays. These are not reset, and a reset cycle blocks the write.
    always_ff @(posedge clk) begin
        if (!rst && (command == c_CMD_WRITE)) begin
            r_tag[w_wr_idx]    <= vaddr_input;
            r_access[w_wr_idx] <= accesstag_w;
            r_phys[w_wr_idx]   <= phys_w;
        end
    end

    // Resolve response. done pulses after a RESOLVE; miss and data hold until the next RESOLVE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_done       <= 1'b0;
            r_miss       <= 1'b0;
            r_res_access <= '0;
            r_res_phys   <= '0;
        end else begin
            r_done <= (command == c_CMD_RESOLVE);
            if (command == c_CMD_RESOLVE) begin
                r_miss       <= !w_hit;
                r_res_access <= w_hit ? r_access[w_hit_idx] : 8'd0;
                r_res_phys   <= w_hit ? r_phys[w_hit_idx]   : 22'd0;
            end
        end
    end

    assign resolve_done      = r_done;
    assign resolve_miss      = r_miss;
    assign resolve_accesstag = r_res_access;
    assign resolve_phys      = r_res_phys;

`ifdef ARMLEOCPU_TLB_STATS_EN
    logic [31:0] r_stat_hits;
    logic [31:0] r_stat_misses;

    // Hit and miss counters. They wrap naturally and are cleared by reset or INVALIDATE_ALL.
    always_ff @(posedge clk) begin
        if (rst || (command == c_CMD_INVALIDATE)) begin
            r_stat_hits   <= '0;
            r_stat_misses <= '0;
        end else if (command == c_CMD_RESOLVE) begin
            if (w_hit) begin
                r_stat_hits <= r_stat_hits + 32'd1;
            end else begin
                r_stat_misses <= r_stat_misses + 32'd1;
            end
        end
    end

    assign stat_hits   = r_stat_hits;
    assign stat_misses = r_stat_misses;
`endif

endmodule
`default_nettype wire

// File: tb/tb_armleocpu_tlb.sv
`default_nettype none
// ============================================================================
// Module   : tb_armleocpu_tlb
// Brief    : Self-checking bench for armleocpu_tlb. It applies directed
//            vectors, hand sequences and random traffic, and checks the
//            results against a FIFO-queue reference model.
// Options  : ARMLEOCPU_TLB_STATS_EN enables the statistics checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_armleocpu_tlb;

    localparam int ENTRIES = 16;
    localparam logic [1:0] c_NONE = 2'd0, c_RES = 2'd1, c_WR = 2'd2, c_INV = 2'd3;

    logic        clk;
    logic        rst;
    logic [1:0]  command;
    logic [19:0] vaddr_input;
    logic [7:0]  accesstag_w;
    logic [21:0] phys_w;
    logic        resolve_done;
    logic        resolve_miss;
    logic [7:0]  resolve_accesstag;
    logic [21:0] resolve_phys;
`ifdef ARMLEOCPU_TLB_STATS_EN
    logic [31:0] stat_hits;
    logic [31:0] stat_misses;
`endif

    armleocpu_tlb #(.ENTRIES(ENTRIES), .ENTRIES_W(4)) u_dut (
        .clk               (clk),
        .rst               (rst),
        .command           (command),
        .vaddr_input       (vaddr_input),
        .accesstag_w       (accesstag_w),
        .phys_w            (phys_w),
        .resolve_done      (resolve_done),
        .resolve_miss      (resolve_miss),
        .resolve_accesstag (resolve_accesstag),
        .resolve_phys      (resolve_phys)
`ifdef ARMLEOCPU_TLB_STATS_EN
        ,
        .stat_hits         (stat_hits),
        .stat_misses       (stat_misses)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, then return 1 time unit after the edge.
    task automatic step(input logic r, input logic [1:0] c, input logic [19:0] va,
                        input logic [7:0] acc, input logic [21:0] ph);
        rst         = r;
        command     = c;
        vaddr_input = va;
        accesstag_w = acc;
        phys_w      = ph;
        @(posedge clk);
        #1;
        rst     = 1'b0;
        command = c_NONE;
    endtask

    task automatic chk_out(input string name, input logic d, input logic m,
                           input logic [7:0] a, input logic [21:0] p);
        chk({name, ".done"}, {31'd0, resolve_done}, {31'd0, d});
        chk({name, ".miss"}, {31'd0, resolve_miss}, {31'd0, m});
        chk({name, ".acc"},  {24'd0, resolve_accesstag}, {24'd0, a});
        chk({name, ".phys"}, {10'd0, resolve_phys}, {10'd0, p});
    endtask

    typedef struct {
        logic [1:0]  cmd;
        logic [19:0] va;
        logic [7:0]  acc;
        logic [21:0] ph;
        logic        e_done;
        logic        e_miss;
        logic [7:0]  e_acc;
        logic [21:0] e_ph;
    } vec_t;

    typedef struct {
        logic [19:0] tag;
        logic [7:0]  acc;
        logic [21:0] ph;
    } ent_t;

    vec_t vecs[9];

    // Reference model. The queue holds entries from oldest fill to newest.
    ent_t        mq[$];
    logic        m_miss;
    logic [7:0]  m_acc;
    logic [21:0] m_ph;
    logic        m_done;
    int unsigned m_hits, m_misses;

    task automatic model_apply(input logic r, input logic [1:0] c, input logic [19:0] va,
                               input logic [7:0] acc, input logic [21:0] ph);
        int idx;
        ent_t e;
        idx = -1;
        foreach (mq[k]) if (mq[k].tag == va) idx = k;
        if (r) begin
            mq.delete();
            m_done = 0; m_miss = 0; m_acc = 0; m_ph = 0;
            m_hits = 0; m_misses = 0;
        end else begin
            m_done = (c == c_RES);
            case (c)
                c_RES: begin
                    m_miss = (idx < 0);
                    m_acc  = (idx < 0) ? 8'd0  : mq[idx].acc;
                    m_ph   = (idx < 0) ? 22'd0 : mq[idx].ph;
                    if (idx < 0) m_misses++; else m_hits++;
                end
                c_WR: begin
                    if (idx >= 0) begin
                        mq[idx].acc = acc;
                        mq[idx].ph  = ph;
                    end else begin
                        if (mq.size() == ENTRIES) void'(mq.pop_front());
                        e.tag = va; e.acc = acc; e.ph = ph;
                        mq.push_back(e);
                    end
                end
                c_INV: begin
                    mq.delete();
                    m_hits = 0; m_misses = 0;
                end
                default: begin
                end
            endcase
        end
    endtask

    initial begin
        rst = 1'b1; command = c_NONE; vaddr_input = '0; accesstag_w = '0; phys_w = '0;

        vecs[0] = '{c_RES,  20'h00001, 8'h00, 22'h0,      1, 1, 8'h00, 22'h0};
        vecs[1] = '{c_WR,   20'h00401, 8'hCF, 22'h000400, 0, 1, 8'h00, 22'h0};
        vecs[2] = '{c_RES,  20'h00401, 8'h00, 22'h0,      1, 0, 8'hCF, 22'h000400};
        vecs[3] = '{c_RES,  20'h00402, 8'h00, 22'h0,      1, 1, 8'h00, 22'h0};
        vecs[4] = '{c_WR,   20'h00401, 8'h0B, 22'h000123, 0, 1, 8'h00, 22'h0};
        vecs[5] = '{c_RES,  20'h00401, 8'h00, 22'h0,      1, 0, 8'h0B, 22'h000123};
        vecs[6] = '{c_NONE, 20'h00401, 8'h00, 22'h0,      0, 0, 8'h0B, 22'h000123};
        vecs[7] = '{c_WR,   20'h00500, 8'h11, 22'h000222, 0, 0, 8'h0B, 22'h000123};
        vecs[8] = '{c_RES,  20'h00500, 8'h00, 22'h0,      1, 0, 8'h11, 22'h000222};

        // Reset state
        step(1, c_NONE, 0, 0, 0);
        step(1, c_NONE, 0, 0, 0);
        chk_out("reset", 0, 0, 8'h00, 22'h0);
`ifdef ARMLEOCPU_TLB_STATS_EN
        chk("reset.hits", stat_hits, 0);
        chk("reset.misses", stat_misses, 0);
`endif

        // Directed vector table
        for (int i = 0; i < 9; i++) begin
            step(0, vecs[i].cmd, vecs[i].va, vecs[i].acc, vecs[i].ph);
            chk_out($sformatf("vec%0d", i), vecs[i].e_done, vecs[i].e_miss, vecs[i].e_acc, vecs[i].e_ph);
        end

        // Flush, then show that all earlier pages miss
        for (int i = 0; i < 3; i++) step(0, c_WR, 20'h00A00 + 20'(i), 8'h03, 22'(i));
        step(0, c_INV, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, c_RES, 20'h00A00 + 20'(i), 0, 0);
            chk_out($sformatf("inv_miss%0d", i), 1, 1, 8'h00, 22'h0);
        end

        // After the flush the fill goes to entry 0. An in-place rewrite leaves the pointer at 1.
        step(0, c_WR, 20'h0B000, 8'h41, 22'h3ABCD);
        step(0, c_WR, 20'h0B000, 8'h43, 22'h3ABCE);
        for (int i = 0; i < 15; i++) step(0, c_WR, 20'h0C000 + 20'(i), 8'h01, 22'(i));
        step(0, c_RES, 20'h0B000, 0, 0);
        chk_out("inplace_kept", 1, 0, 8'h43, 22'h3ABCE);
        step(0, c_WR, 20'h0C0FF, 8'h01, 22'h1);
        step(0, c_RES, 20'h0B000, 0, 0);
        chk_out("inplace_evicted", 1, 1, 8'h00, 22'h0);

        // Write ENTRIES+1 pages: the oldest is evicted and the rest still hit
        step(0, c_INV, 0, 0, 0);
        for (int i = 0; i <= ENTRIES; i++)
            step(0, c_WR, 20'h10000 + 20'(i), 8'h80 + 8'(i), 22'h20000 + 22'(i));
        for (int i = 0; i <= ENTRIES; i++) begin
            step(0, c_RES, 20'h10000 + 20'(i), 0, 0);
            if (i == 0) chk_out("fill_evict", 1, 1, 8'h00, 22'h0);
            else chk_out($sformatf("fill_hit%0d", i), 1, 0, 8'h80 + 8'(i), 22'h20000 + 22'(i));
        end

        // Reset in the same cycle as a RESOLVE that would hit
        step(0, c_WR, 20'h07777, 8'h5F, 22'h15555);
        step(0, c_RES, 20'h07777, 0, 0);
        chk_out("pre_rst_hit", 1, 0, 8'h5F, 22'h15555);
        step(1, c_RES, 20'h07777, 0, 0);
        chk_out("rst_prio", 0, 0, 8'h00, 22'h0);
        step(0, c_RES, 20'h07777, 0, 0);
        chk_out("post_rst_miss", 1, 1, 8'h00, 22'h0);
        step(0, c_WR, 20'h07777, 8'h5F, 22'h15555);
        step(0, c_RES, 20'h07777, 0, 0);
        step(0, c_RES, 20'h07777, 0, 0);
        chk_out("post_rst_hit", 1, 0, 8'h5F, 22'h15555);
`ifdef ARMLEOCPU_TLB_STATS_EN
        chk("stat_hits", stat_hits, 2);
        chk("stat_misses", stat_misses, 1);
        step(0, c_INV, 0, 0, 0);
        chk("stat_inv_hits", stat_hits, 0);
        chk("stat_inv_misses", stat_misses, 0);
`endif

        // Random traffic checked against the queue model
        step(1, c_NONE, 0, 0, 0);
        model_apply(1, c_NONE, 0, 0, 0);
        for (int n = 0; n < 3000; n++) begin
            int unsigned r;
            logic        rr;
            logic [1:0]  c;
            logic [19:0] va;
            logic [7:0]  acc;
            logic [21:0] ph;
            r   = $urandom_range(0, 199);
            rr  = (r == 0);
            c   = (r < 6) ? c_INV : (r < 90) ? c_RES : (r < 170) ? c_WR : c_NONE;
            va  = 20'h30000 + 20'($urandom_range(0, 23));
            acc = 8'($urandom);
            ph  = 22'($urandom);
            step(rr, c, va, acc, ph);
            model_apply(rr, c, va, acc, ph);
            chk_out("rand", m_done, m_miss, m_acc, m_ph);
`ifdef ARMLEOCPU_TLB_STATS_EN
            chk("rand.hits", stat_hits, m_hits);
            chk("rand.misses", stat_misses, m_misses);
`endif
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
